// File: rtl/patcnt_pkg.sv
// Shared types and default constants for the pattern count engine.
package patcnt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SCAN = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4,
        WR2  = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam int         PAT_W         = 5;
    localparam int         MSG_BYTES_DEF = 32;
    localparam logic [7:0] PAT_ADDR_DEF  = 8'd32;
    localparam logic [7:0] RES_ADDR_DEF  = 8'd33;

endpackage

// File: rtl/patcnt_window_match.sv
// Counts 5-bit pattern hits in a 12-bit window {prev[3:0], cur[7:0]}: the four
// windows inside cur and the eight windows ending at each bit of cur.
module patcnt_window_match
    import patcnt_pkg::*;
(
    input  logic [11:0]      window_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic             first_i,
    output logic [2:0]       in_cnt_o,
    output logic [3:0]       cross_cnt_o
);

    always_comb begin
        in_cnt_o    = '0;
        cross_cnt_o = '0;
        for (int j = 0; j < 8; j++) begin
            if (window_i[j +: PAT_W] == pat_i) begin
                if (j < 4) in_cnt_o = in_cnt_o + 3'd1;
                cross_cnt_o = cross_cnt_o + 4'd1;
            end
        end
        // The first byte has no predecessor, so only its own four windows are real.
        if (first_i) cross_cnt_o = {1'b0, in_cnt_o};
    end

endmodule

// File: rtl/pattern_count_engine.sv
// Start/Ack job engine counting 5-bit pattern hits over a 32-byte message in data memory.
// Build option PATCNT_RESTART_EN: Start while busy aborts and relaunches the job.
module pattern_count_engine
    import patcnt_pkg::*;
#(
    parameter int         MSG_BYTES = MSG_BYTES_DEF,
    parameter logic [7:0] PAT_ADDR  = PAT_ADDR_DEF,
    parameter logic [7:0] RES_ADDR  = RES_ADDR_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] MemAddr,
    output logic       MemWrEn,
    output logic [7:0] MemWrData,
    input  logic [7:0] MemRdData
);

    localparam logic [7:0] LAST_IDX = 8'(MSG_BYTES - 1);

    state_t           state_q;
    logic [7:0]       addr_q, wdata_q, idx_q;
    logic             wren_q, ack_q;
    logic [PAT_W-1:0] pat_q;
    logic [3:0]       prev_q;
    logic [7:0]       ctb_q, cto_q, cts_q;
    logic [7:0]       ctb_d, cto_d, cts_d;
    logic [2:0]       in_cnt;
    logic [3:0]       cross_cnt;
    logic             launch;

    patcnt_window_match u_match (
        .window_i    ({prev_q, MemRdData}),
        .pat_i       (pat_q),
        .first_i     (idx_q == 8'd0),
        .in_cnt_o    (in_cnt),
        .cross_cnt_o (cross_cnt)
    );

    assign ctb_d = ctb_q + {5'd0, in_cnt};
    assign cto_d = cto_q + {7'd0, |in_cnt};
    assign cts_d = cts_q + {4'd0, cross_cnt};

`ifdef PATCNT_RESTART_EN
    assign launch = Start;
`else
    assign launch = Start && (state_q == IDLE || state_q == DONE);
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            ack_q   <= 1'b0;
            idx_q   <= '0;
            pat_q   <= '0;
            prev_q  <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
        end else if (launch) begin
            state_q <= LOAD;
            addr_q  <= PAT_ADDR;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            ack_q   <= 1'b0;
            idx_q   <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    pat_q   <= MemRdData[7:3];
                    addr_q  <= '0;
                    idx_q   <= '0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    ctb_q  <= ctb_d;
                    cto_q  <= cto_d;
                    cts_q  <= cts_d;
                    prev_q <= MemRdData[3:0];
                    // Last byte: go straight to the first write with the final in-byte count.
                    if (idx_q == LAST_IDX) begin
                        state_q <= WR0;
                        addr_q  <= RES_ADDR;
                        wren_q  <= 1'b1;
                        wdata_q <= ctb_d;
                    end else begin
                        idx_q  <= idx_q + 8'd1;
                        addr_q <= idx_q + 8'd1;
                    end
                end
                WR0: begin
                    addr_q  <= RES_ADDR + 8'd1;
                    wdata_q <= cto_q;
                    state_q <= WR1;
                end
                WR1: begin
                    addr_q  <= RES_ADDR + 8'd2;
                    wdata_q <= cts_q;
                    state_q <= WR2;
                end
                WR2: begin
                    wren_q  <= 1'b0;
                    state_q <= DONE;
                end
                DONE:    ack_q   <= 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Ack       = ack_q;
    assign MemAddr   = addr_q;
    assign MemWrEn   = wren_q;
    assign MemWrData = wdata_q;

endmodule
